// File: rtl/cache_miss_handler.sv
// Blocking miss handler for a 32-line x 8-word direct-mapped cache: optional
// dirty-line write-back, then an 8-word refill, then a one-cycle fill pulse.
module cache_miss_handler (
    input  logic         clk,
    input  logic         rst,
    input  logic         miss_req,
    input  logic [31:0]  miss_addr,
    input  logic         victim_dirty,
    input  logic [23:0]  victim_tag,
    input  logic [255:0] victim_block,
    output logic         busy,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata,
    output logic         fill_valid,
    output logic [4:0]   fill_index,
    output logic [23:0]  fill_tag,
    output logic [255:0] fill_block
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TAG_W   = 24;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned OFF_W   = 3;
    localparam int unsigned BLOCK_W = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [OFF_W-1:0]     cnt_q, cnt_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [TAG_W-1:0]     vtag_q, vtag_d;
    logic [BLOCK_W-1:0]   vblock_q, vblock_d;
    logic [BLOCK_W-1:0]   fblock_q, fblock_d;
    logic [7:0]           word_lsb;

    // The requested word is not forwarded; the cache re-reads it after the fill.
    logic [OFF_W-1:0]     unused_word;
    assign unused_word = miss_addr[OFF_W-1:0];

    // Word 0 sits in the top bits of a block, so the slice offset is (7 - cnt) * 32.
    assign word_lsb = {~cnt_q, 5'd0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tag_q    <= '0;
            index_q  <= '0;
            vtag_q   <= '0;
            vblock_q <= '0;
            fblock_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            index_q  <= index_d;
            vtag_q   <= vtag_d;
            vblock_q <= vblock_d;
            fblock_q <= fblock_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        index_d    = index_q;
        vtag_d     = vtag_q;
        vblock_d   = vblock_q;
        fblock_d   = fblock_q;
        busy       = (state_q != S_IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (miss_req) begin
                    busy     = 1'b1;
                    tag_d    = miss_addr[31:8];
                    index_d  = miss_addr[7:3];
                    vtag_d   = victim_tag;
                    vblock_d = victim_block;
                    fblock_d = '0;
                    cnt_d    = '0;
                    state_d  = victim_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vtag_q, index_q, cnt_q};
                mem_wdata = vblock_q[word_lsb +: WORD_W];
                if (mem_ack) begin
                    cnt_d = OFF_W'(cnt_q + 3'd1);
                    if (cnt_q == 3'd7) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, index_q, cnt_q};
                if (mem_ack) begin
                    fblock_d[word_lsb +: WORD_W] = mem_rdata;
                    cnt_d = OFF_W'(cnt_q + 3'd1);
                    if (cnt_q == 3'd7) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                fill_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset wins over a same-cycle request or ack.
        if (rst) begin
            busy       = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            fill_valid = 1'b0;
        end
    end

    assign fill_index = index_q;
    assign fill_tag   = tag_q;
    assign fill_block = fblock_q;

endmodule
